// File: rtl/bpsk_phase_gen.sv
// BPSK carrier phase generator: a free-running phase accumulator plus a 180-degree
// offset for the symbol bit in force, producing cosine-LUT addresses per sample.
module bpsk_phase_gen #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int SPS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACC_WIDTH-1:0]  fcw_in,
  input  logic                  fcw_load,
  input  logic [SPS_WIDTH-1:0]  sps_in,
  input  logic                  enable,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic                  lut_addr_valid,
  output logic                  sym_start,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  // Handshake: a bit transfers on a rising edge where bit_valid && bit_ready;
  // bit_ready is combinational and never depends on bit_valid.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc, fcw_reg, acc_next;
  logic [SPS_WIDTH-1:0]   sps_reg, sps_nxt, sym_cnt, cnt_nxt;
  logic                   cur_bit, bit_nxt;
  logic                   valid_nxt, start_nxt, underrun_set;
  logic                   at_last, accept, b;
  logic [ADDR_WIDTH-1:0]  addr_nxt;

  assign acc_next  = acc + fcw_reg;
  assign at_last   = (sym_cnt == sps_reg - SPS_WIDTH'(1));
  // Gated by rst_n so a bit offered on a reset edge is never consumed upstream.
  assign bit_ready = rst_n && enable && ((state == IDLE) || at_last);
  assign accept    = bit_ready && bit_valid;
  assign b         = accept ? bit_in : cur_bit;
  assign addr_nxt  = acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + {b, {(ADDR_WIDTH-1){1'b0}}};

  always_comb begin
    state_nxt    = state;
    sps_nxt      = sps_reg;
    cnt_nxt      = sym_cnt;
    bit_nxt      = cur_bit;
    valid_nxt    = 1'b0;
    start_nxt    = 1'b0;
    underrun_set = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (accept) begin
            bit_nxt   = bit_in;
            sps_nxt   = (sps_in == '0) ? SPS_WIDTH'(1) : sps_in;
            cnt_nxt   = '0;
            start_nxt = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (at_last) begin
            if (accept) begin
              bit_nxt   = bit_in;
              cnt_nxt   = '0;
              start_nxt = 1'b1;
              valid_nxt = 1'b1;
            end else begin
              underrun_set = 1'b1;
              cnt_nxt      = '0;
              state_nxt    = IDLE;
            end
          end else begin
            cnt_nxt   = sym_cnt + SPS_WIDTH'(1);
            valid_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      fcw_reg        <= '0;
      sps_reg        <= SPS_WIDTH'(1);
      sym_cnt        <= '0;
      cur_bit        <= 1'b0;
      lut_addr       <= '0;
      lut_addr_valid <= 1'b0;
      sym_start      <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      if (fcw_load) fcw_reg <= fcw_in;
      underrun       <= underrun_clr ? 1'b0 : (underrun | underrun_set);
      lut_addr_valid <= valid_nxt;
      sym_start      <= start_nxt;
      // Freeze holds the carrier phase and symbol position exactly where they were.
      if (enable) begin
        acc      <= acc_next;
        lut_addr <= addr_nxt;
        state    <= state_nxt;
        sps_reg  <= sps_nxt;
        sym_cnt  <= cnt_nxt;
        cur_bit  <= bit_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_phase_gen.sv
// Bench for bpsk_phase_gen: directed scenarios with literal address streams, then
// random traffic against a sample-level reference model.
module tb_bpsk_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n, fcw_load, enable, bit_in, bit_valid, underrun_clr;
  logic [31:0] fcw_in;
  logic [15:0] sps_in;
  logic        bit_ready, lut_addr_valid, sym_start, underrun;
  logic [8:0]  lut_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] start_q[$];

  // Reference model: carrier phase, samples left in the current symbol, bit in force.
  logic [31:0] m_acc, m_fcw;
  int          m_sps, m_left;
  bit          m_running, m_bit, m_valid, m_start, m_under;
  logic [8:0]  m_addr;

  always #5 clk = ~clk;

  bpsk_phase_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fcw_in         (fcw_in),
    .fcw_load       (fcw_load),
    .sps_in         (sps_in),
    .enable         (enable),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .bit_ready      (bit_ready),
    .lut_addr       (lut_addr),
    .lut_addr_valid (lut_addr_valid),
    .sym_start      (sym_start),
    .underrun       (underrun),
    .underrun_clr   (underrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return rst_n && enable && (!m_running || m_left == 0);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_fcw = 0; m_sps = 1; m_left = 0; m_running = 0;
    m_bit = 0; m_addr = 0; m_valid = 0; m_start = 0; m_under = 0;
  endtask

  task automatic model_update();
    bit take, starved;
    if (!rst_n) begin
      model_reset();
      return;
    end
    take    = model_ready() && bit_valid;
    starved = 0;
    m_valid = 0;
    m_start = 0;
    if (enable) begin
      m_acc = m_acc + m_fcw;
      if (take) begin
        m_bit = bit_in;
        if (!m_running) begin
          m_sps     = (sps_in == 0) ? 1 : int'(sps_in);
          m_running = 1;
        end
        m_left  = m_sps - 1;
        m_valid = 1;
        m_start = 1;
      end else if (m_running && m_left == 0) begin
        m_running = 0;
        starved   = 1;
      end else if (m_running) begin
        m_left  = m_left - 1;
        m_valid = 1;
      end
      m_addr = 9'((m_acc >> 23) + (m_bit ? 32'd256 : 32'd0));
    end
    if (fcw_load) m_fcw = fcw_in;
    m_under = underrun_clr ? 1'b0 : (m_under || starved);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check("bit_ready", 32'(bit_ready), 32'(model_ready()));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("lut_addr_valid", 32'(lut_addr_valid), 32'(m_valid));
    check("sym_start", 32'(sym_start), 32'(m_start));
    check("underrun", 32'(underrun), 32'(m_under));
    check("lut_addr", 32'(lut_addr), 32'(m_addr));
    if (lut_addr_valid) got_q.push_back(lut_addr);
    if (sym_start) start_q.push_back(lut_addr);
  endtask

  task automatic quiet_inputs();
    fcw_load = 0; fcw_in = 0; sps_in = 0; enable = 0;
    bit_in = 0; bit_valid = 0; underrun_clr = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    got_q.delete();
    start_q.delete();
  endtask

  task automatic load_fcw(input logic [31:0] v);
    fcw_in = v; fcw_load = 1; enable = 0;
    step();
    fcw_load = 0;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    quiet_inputs();
    rst_n = 0;

    // Reset held with random inputs
    repeat (3) begin
      fcw_in = $urandom; fcw_load = 1'($urandom); sps_in = 16'($urandom);
      enable = 1'($urandom); bit_in = 1'($urandom); bit_valid = 1'($urandom);
      underrun_clr = 1'($urandom);
      step();
      check("rst_addr", 32'(lut_addr), 0);
      check("rst_valid", 32'(lut_addr_valid), 0);
      check("rst_underrun", 32'(underrun), 0);
    end

    // Steady stream of bits 0,1 then starvation
    do_reset();
    load_fcw(32'h0080_0000);
    sps_in = 4; enable = 1; bit_valid = 1; bit_in = 0;
    step();
    bit_in = 1;
    repeat (4) step();
    bit_valid = 0;
    repeat (4) step();
    exp_q = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd261, 9'd262, 9'd263, 9'd264};
    check_stream("steady_addr");
    got_q = start_q;
    exp_q = '{9'd1, 9'd261};
    check_stream("steady_start");
    check("underrun_set", 32'(underrun), 1);
    check("underrun_valid", 32'(lut_addr_valid), 0);
    bit_valid = 1; bit_in = 0;
    step();
    check("restart_start", 32'(sym_start), 1);
    check("restart_addr", 32'(lut_addr), 10);
    bit_valid = 0; underrun_clr = 1;
    step();
    underrun_clr = 0;
    check("underrun_clr", 32'(underrun), 0);

    // 180-degree wrap with bit 1, then bit 0
    for (int b = 1; b >= 0; b--) begin
      do_reset();
      load_fcw(32'h8000_0000);
      sps_in = 2; enable = 1; bit_valid = 1; bit_in = 1'(b);
      step();
      bit_valid = 0;
      repeat (2) step();
      if (b == 1) exp_q = '{9'd0, 9'd256};
      else        exp_q = '{9'd256, 9'd0};
      check_stream(b == 1 ? "wrap_bit1" : "wrap_bit0");
    end

    // Freeze for 3 cycles mid-symbol
    do_reset();
    load_fcw(32'h0080_0000);
    sps_in = 8; enable = 1; bit_valid = 1; bit_in = 0;
    step();
    bit_valid = 0;
    repeat (2) step();
    enable = 0;
    repeat (3) begin
      step();
      check("freeze_valid", 32'(lut_addr_valid), 0);
      check("freeze_addr", 32'(lut_addr), 3);
    end
    enable = 1;
    repeat (6) step();
    exp_q = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
    check_stream("freeze_addr_seq");
    got_q = start_q;
    exp_q = '{9'd1};
    check_stream("freeze_start");

    // sps_in = 0 behaves as one sample per symbol
    do_reset();
    load_fcw(32'h0080_0000);
    sps_in = 0; enable = 1; bit_valid = 1;
    repeat (6) begin
      bit_in = 1'($urandom);
      step();
      check("sps0_start", 32'(sym_start), 1);
      check("sps0_ready", 32'(bit_ready), 1);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      enable       = ($urandom_range(0, 9) != 0);
      bit_valid    = ($urandom_range(0, 3) != 0);
      bit_in       = 1'($urandom);
      sps_in       = 16'($urandom_range(0, 5));
      fcw_load     = ($urandom_range(0, 19) == 0);
      fcw_in       = $urandom;
      underrun_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_gen.md
# bpsk_phase_gen

Numerically controlled phase generator for the BPSK transmit path. It sits directly upstream of the cosine lookup table and produces the 9-bit phase address that the table converts to an 18-bit carrier sample. Symbol bits are consumed through a valid/ready handshake, and each bit is applied as a 180° phase offset for a programmable number of samples per symbol. Carrier phase stays continuous across symbols, stalls and underruns.

## Interface
- ACC_WIDTH, 32, phase accumulator width.
- ADDR_WIDTH, 9, LUT address width (fixed at 9 to match the cosine table).
- SPS_WIDTH, 16, samples-per-symbol field width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fcw_in  in  ACC_WIDTH  frequency control word.
- fcw_load  in  1  when high, fcw_reg <= fcw_in. The new value is used from the next edge.
- sps_in  in  SPS_WIDTH  samples per symbol. Latched only when a bit is accepted from IDLE.
- enable  in  1  run/freeze control.
- bit_in  in  1  symbol bit (0 → phase 0°, 1 → phase 180°).
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  combinational; the block accepts bit_in on this edge.
- lut_addr  out  ADDR_WIDTH  registered phase address to the cosine LUT.
- lut_addr_valid  out  1  lut_addr is a live sample.
- sym_start  out  1  one-cycle pulse, aligned with the first sample of each symbol.
- underrun  out  1  sticky; set when a symbol ends with no next bit available.
- underrun_clr  in  1  clears underrun.

## Operation
- The state machine has two states: IDLE and RUN.
- An advance edge is a rising edge with rst_n=1 and enable=1. On every advance edge, in either state:
  - acc <= acc + fcw_reg, mod 2^ACC_WIDTH.
  - Carrier phase is never reset by symbol boundaries.
- When enable=0, the block freezes: acc, sym_cnt, state and cur_bit hold, and lut_addr_valid <= 0.
- bit_ready = enable && (state==IDLE || (state==RUN && sym_cnt==sps_reg-1)).
- Acceptance happens when bit_ready && bit_valid.
- IDLE:
  - lut_addr_valid <= 0, sym_start <= 0.
  - On acceptance: cur_bit <= bit_in, sps_reg <= (sps_in==0 ? 1 : sps_in), sym_cnt <= 0, sym_start <= 1, go to RUN.
- RUN:
  - Each advance edge: sym_cnt <= sym_cnt+1 and lut_addr_valid <= 1.
  - At sym_cnt==sps_reg-1 with acceptance: cur_bit <= bit_in, sym_cnt <= 0, sym_start <= 1. sps_reg is unchanged.
  - At sym_cnt==sps_reg-1 without bit_valid: underrun <= 1, go to IDLE, lut_addr_valid <= 0.
- Address computation:
  - lut_addr <= acc_next[ACC_WIDTH-1 -: 9] + {b, 8'b0}, mod 512.
  - acc_next = acc + fcw_reg.
  - b is the bit in force for that sample: the newly accepted bit on an accept edge, otherwise cur_bit.
- underrun_clr has priority over a simultaneous set: the flag clears.
- fcw_load takes effect at any time, including mid-symbol. There is no phase jump; only the increment changes.

## Timing
- Reset values: acc=0, fcw_reg=0, sps_reg=1, sym_cnt=0, cur_bit=0, state=IDLE, lut_addr=0, lut_addr_valid=0, sym_start=0, underrun=0. bit_ready=0 while enable=0.
- Reset asserted mid-run: everything returns to its reset value on that edge, and any bit offered on that edge is not accepted.
- Latency:
  - The address for sample k appears one cycle after the advance edge that produced it.
  - The first valid sample of a symbol appears on the edge after acceptance, and that edge also carries the first sym_start.
- Back-to-back symbols produce no gap: exactly sps_reg valid samples per symbol while bits keep arriving.
- After an underrun, exactly one IDLE cycle elapses before a new acceptance, if bit_valid is high at that point.
- enable deasserted mid-symbol: lut_addr_valid falls on the next edge. The remaining count resumes when enable returns, with no extra sym_start.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → every output stays 0 and bit_ready stays 0.
- Steady stream:
  - Setup: fcw=2^23, sps=4, bits 0,1 held valid, enable rising together with the first bit.
  - Required: lut_addr 1,2,3,4 then 261,262,263,264, with sym_start on the samples at addr 1 and addr 261.
- Underrun:
  - Setup: same as above, but bit_valid drops after the first bit.
  - Required: 4 valid samples, then lut_addr_valid=0 and underrun=1. A new bit restarts with a fresh sym_start. underrun_clr clears the flag.
- Wrap / 180°:
  - Setup: fcw=2^31, sps=2, bit 1.
  - Required: addresses 0,256 (256+256 wraps mod 512). With bit 0, the addresses are 256,0.
- Freeze: deassert enable for 3 cycles mid-symbol → lut_addr and sym_cnt hold, lut_addr_valid=0, and output resumes at the next address.
- sps_in=0: handled as 1 → bit_ready is high every RUN cycle, and sym_start pulses every sample.
